ysyx_22050598_exu_bru: RTL and testbench

Branch resolution unit in the EX stage; the consuming end of the IFU static predictor. For every accepted control-transfer instruction it evaluates the real outcome, compares it with the prediction carried down the pipe, and on mismatch (or any JALR) issues a held redirect to the IFU plus a one-cycle flush of younger stages. It also releases the IFU's JALR stall and keeps saturating branch and mispredict counters.

---
 rtl/ysyx_22050598_exu_bru_pkg.sv | 33 +++
 rtl/ysyx_22050598_exu_bru_cmp.sv | 30 +++
 rtl/ysyx_22050598_exu_bru.sv | 110 +++++++++++
 tb/tb_ysyx_22050598_exu_bru.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22050598_exu_bru_pkg.sv
// Shared opcode/funct3 encodings, FSM state type and immediate decoders for the EX-stage branch unit.
package ysyx_22050598_exu_bru_pkg;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;
    localparam logic [2:0] F3_JALR = 3'b000;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_REDIR = 1'b1
    } bru_state_e;

    function automatic logic [63:0] b_imm(input logic [31:0] inst);
        return {{52{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
    endfunction

    function automatic logic [63:0] j_imm(input logic [31:0] inst);
        return {{44{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
    endfunction

    function automatic logic [63:0] i_imm(input logic [31:0] inst);
        return {{52{inst[31]}}, inst[31:20]};
    endfunction

endpackage

// File: rtl/ysyx_22050598_exu_bru_cmp.sv
// Combinational branch condition evaluator selected by funct3.
module ysyx_22050598_exu_bru_cmp
    import ysyx_22050598_exu_bru_pkg::*;
(
    input  logic [63:0] src1,
    input  logic [63:0] src2,
    input  logic [2:0]  funct3,
    output logic        taken
);

    logic signed [63:0] src1_s;
    logic signed [63:0] src2_s;

    assign src1_s = src1;
    assign src2_s = src2;

    always_comb begin
        taken = 1'b0;
        case (funct3)
            F3_BEQ:  taken = (src1 == src2);
            F3_BNE:  taken = (src1 != src2);
            F3_BLT:  taken = (src1_s <  src2_s);
            F3_BGE:  taken = (src1_s >= src2_s);
            F3_BLTU: taken = (src1 <  src2);
            F3_BGEU: taken = (src1 >= src2);
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/ysyx_22050598_exu_bru.sv
// EX-stage branch resolution: checks fetch-time predictions, raises held redirects and flushes,
// releases the IFU JALR stall and keeps saturating branch/mispredict statistics.
module ysyx_22050598_exu_bru
    import ysyx_22050598_exu_bru_pkg::*;
#(
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ex_valid,
    output logic             ex_ready,
    input  logic [63:0]      ex_pc,
    input  logic [31:0]      ex_inst,
    input  logic [63:0]      ex_src1,
    input  logic [63:0]      ex_src2,
    input  logic             ex_prdt_taken,
    output logic             redirect_valid,
    input  logic             redirect_ready,
    output logic [63:0]      redirect_pc,
    output logic             flush,
    output logic             jalr_done,
    output logic [CNT_W-1:0] stat_br_cnt,
    output logic [CNT_W-1:0] stat_mis_cnt
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    bru_state_e  state, state_nxt;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        is_br, is_jal, is_jalr, is_pred;
    logic        cmp_taken, act_taken, mispredict;
    logic        accept, start, fire;
    logic [63:0] pc_offset, seq_pc, jalr_tgt, next_pc;
    logic        jalr_flag, flush_q;

    assign opcode  = ex_inst[6:0];
    assign funct3  = ex_inst[14:12];
    assign is_br   = (opcode == OPC_BRANCH);
    assign is_jal  = (opcode == OPC_JAL);
    assign is_jalr = (opcode == OPC_JALR) && (funct3 == F3_JALR);
    assign is_pred = is_br | is_jal;

    ysyx_22050598_exu_bru_cmp u_cmp (
        .src1   (ex_src1),
        .src2   (ex_src2),
        .funct3 (funct3),
        .taken  (cmp_taken)
    );

    assign act_taken  = is_jal | (is_br & cmp_taken);
    assign mispredict = is_pred & (act_taken != ex_prdt_taken);

    assign pc_offset = is_jal ? j_imm(ex_inst) : b_imm(ex_inst);
    assign seq_pc    = ex_pc + 64'd4;
    assign jalr_tgt  = (ex_src1 + i_imm(ex_inst)) & ~64'd1;
    assign next_pc   = is_jalr   ? jalr_tgt :
                       act_taken ? (ex_pc + pc_offset) : seq_pc;

    assign ex_ready       = (state == ST_IDLE);
    assign redirect_valid = (state == ST_REDIR);
    assign accept         = ex_valid & ex_ready;
    assign start          = accept & (mispredict | is_jalr);
    assign fire           = redirect_valid & redirect_ready;
    assign flush          = flush_q;
    assign jalr_done      = fire & jalr_flag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_REDIR;
            ST_REDIR: if (redirect_ready) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // start can only occur in IDLE, so flush_q marks exactly the first REDIR cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_pc  <= 64'd0;
            jalr_flag    <= 1'b0;
            flush_q      <= 1'b0;
            stat_br_cnt  <= '0;
            stat_mis_cnt <= '0;
        end else begin
            flush_q <= start;
            if (start) begin
                redirect_pc <= next_pc;
                jalr_flag   <= is_jalr;
            end
            if (accept && is_pred) begin
                stat_br_cnt <= sat_inc(stat_br_cnt);
            end
            if (accept && mispredict) begin
                stat_mis_cnt <= sat_inc(stat_mis_cnt);
            end
        end
    end

endmodule

// File: tb/tb_ysyx_22050598_exu_bru.sv
// Randomized and directed bench for the EX-stage branch unit against a behavioural model.
module tb_ysyx_22050598_exu_bru;

    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             ex_valid = 1'b0;
    logic             ex_ready;
    logic [63:0]      ex_pc = '0;
    logic [31:0]      ex_inst = '0;
    logic [63:0]      ex_src1 = '0;
    logic [63:0]      ex_src2 = '0;
    logic             ex_prdt_taken = 1'b0;
    logic             redirect_valid;
    logic             redirect_ready = 1'b0;
    logic [63:0]      redirect_pc;
    logic             flush;
    logic             jalr_done;
    logic [CNT_W-1:0] stat_br_cnt;
    logic [CNT_W-1:0] stat_mis_cnt;

    ysyx_22050598_exu_bru #(.CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ex_valid       (ex_valid),
        .ex_ready       (ex_ready),
        .ex_pc          (ex_pc),
        .ex_inst        (ex_inst),
        .ex_src1        (ex_src1),
        .ex_src2        (ex_src2),
        .ex_prdt_taken  (ex_prdt_taken),
        .redirect_valid (redirect_valid),
        .redirect_ready (redirect_ready),
        .redirect_pc    (redirect_pc),
        .flush          (flush),
        .jalr_done      (jalr_done),
        .stat_br_cnt    (stat_br_cnt),
        .stat_mis_cnt   (stat_mis_cnt)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // behavioural model state
    bit          m_pend;
    bit          m_jalr;
    bit          m_first;
    logic [63:0] m_pc;
    int          m_br;
    int          m_mis;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [12:0] imm);
        return {imm[12], imm[10:5], 5'd2, 5'd1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_jalr(input logic [11:0] imm);
        return {imm, 5'd1, 3'b000, 5'd1, 7'b1100111};
    endfunction

    // Architectural outcome of one instruction, straight from the ISA rules.
    task automatic resolve(input logic [63:0] pc, input logic [31:0] inst, input logic [63:0] a,
                           input logic [63:0] b, input bit prdt, output bit ctl, output bit redir,
                           output bit mis, output bit jalr, output logic [63:0] tgt);
        longint off;
        bit     taken;
        ctl = 0; jalr = 0; taken = 0; off = 0; tgt = pc + 64'd4;
        if (inst[6:0] == 7'b1100011) begin
            ctl = 1;
            off = longint'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
            case (inst[14:12])
                3'd0: taken = (a == b);
                3'd1: taken = (a != b);
                3'd4: taken = ($signed(a) < $signed(b));
                3'd5: taken = !($signed(a) < $signed(b));
                3'd6: taken = (a < b);
                3'd7: taken = !(a < b);
                default: taken = 0;
            endcase
        end else if (inst[6:0] == 7'b1101111) begin
            ctl = 1;
            taken = 1;
            off = longint'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
        end else if (inst[6:0] == 7'b1100111 && inst[14:12] == 3'd0) begin
            jalr = 1;
        end
        if (taken) tgt = pc + 64'(off);
        if (jalr) tgt = (a + 64'(longint'($signed(inst[31:20])))) & ~64'd1;
        mis = ctl && (taken != prdt);
        redir = mis || jalr;
    endtask

    task automatic model_reset();
        m_pend = 0; m_jalr = 0; m_first = 0; m_pc = '0; m_br = 0; m_mis = 0;
    endtask

    // One clock: compare outputs at negedge with the model, advance the model, then move past posedge.
    task automatic step();
        bit ctl, redir, mis, jalr;
        logic [63:0] tgt;
        @(negedge clk);
        chk("ex_ready", 64'(ex_ready), 64'(!m_pend));
        chk("redirect_valid", 64'(redirect_valid), 64'(m_pend));
        if (m_pend) chk("redirect_pc", redirect_pc, m_pc);
        chk("flush", 64'(flush), 64'(m_first));
        chk("jalr_done", 64'(jalr_done), 64'(m_pend && redirect_ready && m_jalr));
        chk("br_cnt", 64'(stat_br_cnt), 64'(m_br));
        chk("mis_cnt", 64'(stat_mis_cnt), 64'(m_mis));
        if (m_pend) begin
            m_first = 0;
            if (redirect_ready) m_pend = 0;
        end else if (ex_valid) begin
            m_first = 0;
            resolve(ex_pc, ex_inst, ex_src1, ex_src2, ex_prdt_taken, ctl, redir, mis, jalr, tgt);
            if (ctl && m_br < CNT_MAX) m_br++;
            if (mis && m_mis < CNT_MAX) m_mis++;
            if (redir) begin
                m_pend = 1; m_first = 1; m_pc = tgt; m_jalr = jalr;
            end
        end else begin
            m_first = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 0; ex_valid = 0; redirect_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ex_ready", 64'(ex_ready), 64'd1);
        chk("rst_redirect_valid", 64'(redirect_valid), 64'd0);
        chk("rst_redirect_pc", redirect_pc, 64'd0);
        chk("rst_counters", 64'({stat_br_cnt, stat_mis_cnt}), 64'd0);
        model_reset();
        rst_n = 1;
    endtask

    task automatic issue(input logic [63:0] pc, input logic [31:0] inst, input logic [63:0] a,
                         input logic [63:0] b, input bit prdt);
        ex_valid = 1; ex_pc = pc; ex_inst = inst; ex_src1 = a; ex_src2 = b; ex_prdt_taken = prdt;
        step();
        ex_valid = 0;
    endtask

    initial begin
        logic [31:0] r;
        logic [63:0] pick;
        do_reset();

        // beq taken, predicted not-taken
        redirect_ready = 0;
        issue(64'h8000_0000, enc_b(3'b000, 13'd16), 64'd5, 64'd5, 1'b0);
        step();
        chk("beq_redirect_pc", redirect_pc, 64'h8000_0010);
        chk("beq_mis_cnt", 64'(stat_mis_cnt), 64'd1);
        chk("beq_flush_once", 64'(flush), 64'd0);
        redirect_ready = 1;
        step();
        redirect_ready = 0;

        // blt taken, predicted taken: no redirect
        issue(64'h8000_0100, enc_b(3'b100, 13'h1FF8), 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b1);
        chk("blt_ready", 64'(ex_ready), 64'd1);
        chk("blt_br_cnt", 64'(stat_br_cnt), 64'd2);
        chk("blt_mis_cnt", 64'(stat_mis_cnt), 64'd1);
        step();

        // bltu same operands: not taken, mispredicted
        issue(64'h8000_0100, enc_b(3'b110, 13'h1FF8), 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b1);
        step();
        chk("bltu_redirect_pc", redirect_pc, 64'h8000_0104);
        chk("bltu_mis_cnt", 64'(stat_mis_cnt), 64'd2);
        redirect_ready = 1;
        step();
        redirect_ready = 0;

        // jalr with the IFU stalling the redirect for three cycles
        issue(64'h8000_0200, enc_jalr(12'd3), 64'h8000_1001, 64'd0, 1'b0);
        repeat (3) step();
        chk("jalr_redirect_pc", redirect_pc, 64'h8000_1004);
        chk("jalr_done_early", 64'(jalr_done), 64'd0);
        redirect_ready = 1;
        #1;
        chk("jalr_done_fire", 64'(jalr_done), 64'd1);
        step();
        redirect_ready = 0;
        chk("jalr_counters", 64'({stat_br_cnt, stat_mis_cnt}), 64'h32);

        // asynchronous reset while a redirect is pending
        issue(64'h8000_0300, enc_b(3'b001, 13'd32), 64'd1, 64'd2, 1'b0);
        #2;
        rst_n = 0;
        #1;
        chk("arst_redirect_valid", 64'(redirect_valid), 64'd0);
        chk("arst_ex_ready", 64'(ex_ready), 64'd1);
        chk("arst_flush", 64'(flush), 64'd0);
        chk("arst_redirect_pc", redirect_pc, 64'd0);
        chk("arst_counters", 64'({stat_br_cnt, stat_mis_cnt}), 64'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1;
        redirect_ready = 1;
        repeat (2) step();

        // mispredict counter saturation
        do_reset();
        redirect_ready = 1;
        for (int i = 0; i < CNT_MAX + 3; i++) begin
            issue(64'h8000_0000, enc_b(3'b000, 13'd8), 64'd7, 64'd7, 1'b0);
            step();
        end
        chk("sat_mis_cnt", 64'(stat_mis_cnt), 64'(CNT_MAX));
        chk("sat_br_cnt", 64'(stat_br_cnt), 64'(CNT_MAX));

        // randomized traffic, reset between segments so counters stay informative
        for (int seg = 0; seg < 25; seg++) begin
            do_reset();
            for (int c = 0; c < 50; c++) begin
                r = $urandom;
                case ($urandom_range(0, 5))
                    0, 1:    ex_inst = {r[31:7], 7'b1100011};
                    2:       ex_inst = {r[31:7], 7'b1101111};
                    3:       ex_inst = {r[31:15], 3'b000, r[11:7], 7'b1100111};
                    4:       ex_inst = {r[31:7], 7'b1100111};
                    default: ex_inst = {r[31:7], 7'b0110011};
                endcase
                ex_pc = {$urandom, $urandom} & ~64'd3;
                ex_src1 = {$urandom, $urandom};
                case ($urandom_range(0, 3))
                    0:       pick = ex_src1;
                    1:       pick = 64'h8000_0000_0000_0000;
                    2:       pick = ~ex_src1;
                    default: pick = {$urandom, $urandom};
                endcase
                ex_src2 = pick;
                ex_prdt_taken = $urandom_range(0, 1);
                ex_valid = ($urandom_range(0, 3) != 0);
                redirect_ready = ($urandom_range(0, 1) != 0);
                step();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
